// File: rtl/control_ascensor.sv
// control_ascensor: motion/door controller for a 4-floor elevator.
// Consumes the next-request code from the request memory and returns the
// current floor, motion action and door state. Travel and door dwell are
// timed with cycle counters instead of shaft sensors.
//
// Optional feature macro: DOOR_REOPEN_EN (cabin door-open button).
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   memoria      next request code (0 = none, 11..15 invalid)
//   boton_abrir  cabin door-open button (only with DOOR_REOPEN_EN)
//   piso         current floor, 0..3
//   accion       0 = stopped, 1 = moving up, 2 = moving down
//   puertas      1 = door open
//   llegada      one-cycle pulse on arrival at any floor
//   destino      latched target floor
module control_ascensor #(
    parameter int unsigned TRAVEL_CYCLES = 100,
    parameter int unsigned DOOR_CYCLES   = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] memoria,
    input  logic       boton_abrir,
    output logic [1:0] piso,
    output logic [1:0] accion,
    output logic       puertas,
    output logic       llegada,
    output logic [1:0] destino
);
    localparam int unsigned TW = $clog2(TRAVEL_CYCLES);
    localparam int unsigned DW = $clog2(DOOR_CYCLES);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

    localparam logic [1:0] ACC_STOP = 2'd0;
    localparam logic [1:0] ACC_UP   = 2'd1;
    localparam logic [1:0] ACC_DOWN = 2'd2;

    typedef enum logic [1:0] {IDLE, UP, DOWN, DOOR_OPEN} state_t;

    state_t        state, state_n;
    logic [1:0]    piso_n, accion_n, destino_n;
    logic          puertas_n, llegada_n;
    logic [TW-1:0] travel_cnt, travel_n;
    logic [DW-1:0] door_cnt, door_n;

    logic          req_valid_c;
    logic [1:0]    req_tgt_c;
    logic [1:0]    dest_eff_c;
    logic [1:0]    piso_step_c;
    logic          reopen_c;

`ifdef DOOR_REOPEN_EN
    assign reopen_c = boton_abrir;
`else
    logic unused_boton;
    assign unused_boton = boton_abrir;
    assign reopen_c     = 1'b0;
`endif

    // Request code decode to target floor
    always_comb begin
        req_valid_c = 1'b1;
        req_tgt_c   = 2'd0;
        case (memoria)
            4'd1, 4'd5:        req_tgt_c = 2'd0;
            4'd2, 4'd6, 4'd7:  req_tgt_c = 2'd1;
            4'd3, 4'd8, 4'd9:  req_tgt_c = 2'd2;
            4'd4, 4'd10:       req_tgt_c = 2'd3;
            default:           req_valid_c = 1'b0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n     = state;
        piso_n      = piso;
        accion_n    = accion;
        puertas_n   = puertas;
        llegada_n   = 1'b0;
        destino_n   = destino;
        travel_n    = travel_cnt;
        door_n      = door_cnt;
        // Arrival decisions see a same-edge target update
        dest_eff_c  = req_valid_c ? req_tgt_c : destino;
        piso_step_c = piso;

        if (state != DOOR_OPEN && req_valid_c)
            destino_n = req_tgt_c;

        case (state)
            IDLE: begin
                if (req_valid_c) begin
                    if (req_tgt_c == piso) begin
                        state_n   = DOOR_OPEN;
                        puertas_n = 1'b1;
                        door_n    = '0;
                    end else if (req_tgt_c > piso) begin
                        state_n  = UP;
                        accion_n = ACC_UP;
                        travel_n = '0;
                    end else begin
                        state_n  = DOWN;
                        accion_n = ACC_DOWN;
                        travel_n = '0;
                    end
                end else if (reopen_c) begin
                    state_n   = DOOR_OPEN;
                    puertas_n = 1'b1;
                    door_n    = '0;
                end
            end
            UP: begin
                if (travel_cnt == TRAVEL_LAST) begin
                    piso_step_c = (piso == 2'd3) ? piso : piso + 2'd1;
                    piso_n      = piso_step_c;
                    travel_n    = '0;
                    llegada_n   = 1'b1;
                    if (piso_step_c == dest_eff_c || piso_step_c == 2'd3) begin
                        state_n   = DOOR_OPEN;
                        accion_n  = ACC_STOP;
                        puertas_n = 1'b1;
                        door_n    = '0;
                    end else if (dest_eff_c < piso_step_c) begin
                        state_n  = IDLE;
                        accion_n = ACC_STOP;
                    end
                end else begin
                    travel_n = travel_cnt + TW'(1);
                end
            end
            DOWN: begin
                if (travel_cnt == TRAVEL_LAST) begin
                    piso_step_c = (piso == 2'd0) ? piso : piso - 2'd1;
                    piso_n      = piso_step_c;
                    travel_n    = '0;
                    llegada_n   = 1'b1;
                    if (piso_step_c == dest_eff_c || piso_step_c == 2'd0) begin
                        state_n   = DOOR_OPEN;
                        accion_n  = ACC_STOP;
                        puertas_n = 1'b1;
                        door_n    = '0;
                    end else if (dest_eff_c > piso_step_c) begin
                        state_n  = IDLE;
                        accion_n = ACC_STOP;
                    end
                end else begin
                    travel_n = travel_cnt + TW'(1);
                end
            end
            DOOR_OPEN: begin
                // Button hold restarts the dwell, taking priority over closing
                if (reopen_c) begin
                    door_n = '0;
                end else if (door_cnt == DOOR_LAST) begin
                    state_n   = IDLE;
                    puertas_n = 1'b0;
                    door_n    = '0;
                end else begin
                    door_n = door_cnt + DW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            piso       <= 2'd0;
            accion     <= ACC_STOP;
            puertas    <= 1'b0;
            llegada    <= 1'b0;
            destino    <= 2'd0;
            travel_cnt <= '0;
            door_cnt   <= '0;
        end else begin
            state      <= state_n;
            piso       <= piso_n;
            accion     <= accion_n;
            puertas    <= puertas_n;
            llegada    <= llegada_n;
            destino    <= destino_n;
            travel_cnt <= travel_n;
            door_cnt   <= door_n;
        end
    end
endmodule

// File: tb/tb_control_ascensor.sv
// Bench for control_ascensor: directed scenarios followed by a long random
// run compared each cycle against a countdown-based behavioural model.
module tb_control_ascensor;
    localparam int TRAVEL = 100;
    localparam int DOOR   = 50;
`ifdef DOOR_REOPEN_EN
    localparam bit REOPEN = 1'b1;
`else
    localparam bit REOPEN = 1'b0;
`endif

    localparam int MODE_IDLE = 0;
    localparam int MODE_UP   = 1;
    localparam int MODE_DOWN = 2;
    localparam int MODE_DOOR = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] memoria;
    logic       boton_abrir;
    logic [1:0] piso;
    logic [1:0] accion;
    logic       puertas;
    logic       llegada;
    logic [1:0] destino;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int m_piso, m_mode, m_left, m_dest;
    bit m_lleg;

    control_ascensor #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
        .clk(clk), .reset(reset), .memoria(memoria), .boton_abrir(boton_abrir),
        .piso(piso), .accion(accion), .puertas(puertas), .llegada(llegada),
        .destino(destino)
    );

    always #5 clk = ~clk;

    // Target floor from request code, -1 if the code is not a request
    function automatic int tgt_of(input int c);
        if (c >= 1 && c <= 4)  return c - 1;
        if (c >= 5 && c <= 10) return (c - 4) / 2;
        return -1;
    endfunction

    task automatic model_reset();
        m_piso = 0; m_mode = MODE_IDLE; m_left = 0; m_dest = 0; m_lleg = 1'b0;
    endtask

    task automatic open_door();
        m_mode = MODE_DOOR;
        m_left = DOOR;
    endtask

    // One clock edge of the elevator, expressed as cycles remaining to the next event
    task automatic model_step(input int mem, input bit btn);
        int t;
        int stop_floor;
        bit going_up;
        t = tgt_of(mem);
        m_lleg = 1'b0;
        if (m_mode == MODE_IDLE) begin
            if (t >= 0) begin
                m_dest = t;
                if (t == m_piso)     open_door();
                else begin
                    m_mode = (t > m_piso) ? MODE_UP : MODE_DOWN;
                    m_left = TRAVEL;
                end
            end else if (REOPEN && btn) begin
                open_door();
            end
        end else if (m_mode == MODE_DOOR) begin
            if (REOPEN && btn) m_left = DOOR;
            else begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = MODE_IDLE;
            end
        end else begin
            going_up = (m_mode == MODE_UP);
            if (t >= 0) m_dest = t;
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_piso = going_up ? m_piso + 1 : m_piso - 1;
                if (m_piso > 3) m_piso = 3;
                if (m_piso < 0) m_piso = 0;
                m_lleg = 1'b1;
                stop_floor = going_up ? 3 : 0;
                if (m_piso == m_dest || m_piso == stop_floor) open_door();
                else if (going_up ? (m_dest < m_piso) : (m_dest > m_piso)) m_mode = MODE_IDLE;
                else m_left = TRAVEL;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step(int'(memoria), boton_abrir);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; memoria = 4'd0; boton_abrir = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (piso !== 2'd0 || accion !== 2'd0 || destino !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_pos: piso=%0d accion=%0d destino=%0d, want 0 0 0", piso, accion, destino);
        end
        tick(); tick();
        n_checks++;
        if (puertas !== 1'b0 || llegada !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_door: puertas=%0b llegada=%0b, want 0 0", puertas, llegada);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_same_floor();
        memoria = 4'd5; tick(); memoria = 4'd0;
        n_checks++;
        if (puertas !== 1'b1 || accion !== 2'd0) begin
            n_errors++;
            $display("FAIL same_floor_open: puertas=%0b accion=%0d, want 1 0", puertas, accion);
        end
        repeat (DOOR - 1) tick();
        n_checks++;
        if (puertas !== 1'b1) begin
            n_errors++;
            $display("FAIL same_floor_dwell: puertas=%0b, want 1", puertas);
        end
        tick();
        n_checks++;
        if (puertas !== 1'b0 || accion !== 2'd0) begin
            n_errors++;
            $display("FAIL same_floor_close: puertas=%0b accion=%0d, want 0 0", puertas, accion);
        end
    endtask

    task automatic test_up_trip();
        int pulses = 0;
        memoria = 4'd4; tick(); memoria = 4'd0;
        n_checks++;
        if (accion !== 2'd1 || destino !== 2'd3) begin
            n_errors++;
            $display("FAIL up_start: accion=%0d destino=%0d, want 1 3", accion, destino);
        end
        for (int i = 1; i <= 3 * TRAVEL; i++) begin
            tick();
            if (llegada === 1'b1) pulses++;
            if (i == TRAVEL - 1 || i == TRAVEL || i == 2 * TRAVEL) begin
                n_checks++;
                if (piso !== 2'(i / TRAVEL)) begin
                    n_errors++;
                    $display("FAIL up_floor_step cycle %0d: piso=%0d, want %0d", i, piso, i / TRAVEL);
                end
            end
        end
        n_checks++;
        if (piso !== 2'd3 || accion !== 2'd0 || puertas !== 1'b1 || pulses != 3) begin
            n_errors++;
            $display("FAIL up_arrive: piso=%0d accion=%0d puertas=%0b pulses=%0d, want 3 0 1 3",
                     piso, accion, puertas, pulses);
        end
        repeat (DOOR) tick();
        n_checks++;
        if (puertas !== 1'b0) begin
            n_errors++;
            $display("FAIL up_door_close: puertas=%0b, want 0", puertas);
        end
    endtask

    task automatic test_down_redirect();
        int pulses = 0;
        bit reached0 = 1'b0;
        memoria = 4'd1; tick(); memoria = 4'd0;
        n_checks++;
        if (accion !== 2'd2 || destino !== 2'd0) begin
            n_errors++;
            $display("FAIL down_start: accion=%0d destino=%0d, want 2 0", accion, destino);
        end
        for (int i = 1; i <= 2 * TRAVEL; i++) begin
            memoria = (i == 150) ? 4'd6 : 4'd0;
            tick();
            if (llegada === 1'b1) pulses++;
        end
        memoria = 4'd0;
        n_checks++;
        if (piso !== 2'd1 || puertas !== 1'b1 || accion !== 2'd0 || destino !== 2'd1 || pulses != 2) begin
            n_errors++;
            $display("FAIL down_redirect_stop: piso=%0d puertas=%0b accion=%0d destino=%0d pulses=%0d, want 1 1 0 1 2",
                     piso, puertas, accion, destino, pulses);
        end
        for (int i = 0; i < 260; i++) begin
            tick();
            if (piso === 2'd0) reached0 = 1'b1;
        end
        n_checks++;
        if (reached0 || piso !== 2'd1 || puertas !== 1'b0) begin
            n_errors++;
            $display("FAIL down_no_floor0: reached0=%0b piso=%0d puertas=%0b, want 0 1 0", reached0, piso, puertas);
        end
    endtask

    task automatic test_invalid();
        bit changed = 1'b0;
        int v;
        for (int i = 0; i < 200; i++) begin
            v = $urandom_range(11, 16);
            if (i == 0) v = 12;
            memoria = (v == 16) ? 4'd0 : 4'(v);
            tick();
            if (piso !== 2'd1 || accion !== 2'd0 || puertas !== 1'b0 || llegada !== 1'b0 || destino !== 2'd1)
                changed = 1'b1;
        end
        memoria = 4'd0;
        n_checks++;
        if (changed) begin
            n_errors++;
            $display("FAIL invalid_codes: outputs changed, now piso=%0d accion=%0d puertas=%0b destino=%0d",
                     piso, accion, puertas, destino);
        end
    endtask

    task automatic test_reset_mid_up();
        memoria = 4'd4; tick(); memoria = 4'd0;
        repeat (40) tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (piso !== 2'd0 || accion !== 2'd0 || puertas !== 1'b0 || llegada !== 1'b0 || destino !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_mid_up: piso=%0d accion=%0d puertas=%0b llegada=%0b destino=%0d, want all 0",
                     piso, accion, puertas, llegada, destino);
        end
        tick();
        reset = 1'b0;
        memoria = 4'd2; tick(); memoria = 4'd0;
        n_checks++;
        if (accion !== 2'd1 || piso !== 2'd0) begin
            n_errors++;
            $display("FAIL restart_from_0: accion=%0d piso=%0d, want 1 0", accion, piso);
        end
        repeat (TRAVEL) tick();
        n_checks++;
        if (piso !== 2'd1 || puertas !== 1'b1) begin
            n_errors++;
            $display("FAIL restart_arrive: piso=%0d puertas=%0b, want 1 1", piso, puertas);
        end
        repeat (DOOR) tick();
    endtask

    task automatic test_reopen();
        int closed_at = -1;
        int want_close;
        want_close = REOPEN ? 46 + DOOR : DOOR;
        memoria = 4'd2; tick(); memoria = 4'd0;
        repeat (45) tick();
        boton_abrir = 1'b1; tick(); boton_abrir = 1'b0;
        for (int k = 47; k <= 120; k++) begin
            tick();
            if (closed_at < 0 && puertas === 1'b0) closed_at = k;
        end
        n_checks++;
        if (closed_at != want_close) begin
            n_errors++;
            $display("FAIL door_reopen: closed at cycle %0d, want %0d", closed_at, want_close);
        end
    endtask

    task automatic test_random();
        int r;
        int shown = 0;
        logic [1:0] exp_acc;
        for (int i = 0; i < 20000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 6)       memoria = 4'($urandom_range(1, 10));
            else if (r < 10) memoria = 4'($urandom_range(11, 15));
            else             memoria = 4'd0;
            boton_abrir = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3999) == 0) begin
                reset = 1'b1;
                model_reset();
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
            exp_acc = (m_mode == MODE_UP) ? 2'd1 : (m_mode == MODE_DOWN) ? 2'd2 : 2'd0;
            n_checks++;
            if (piso !== 2'(m_piso) || accion !== exp_acc || puertas !== (m_mode == MODE_DOOR) ||
                llegada !== m_lleg || destino !== 2'(m_dest)) begin
                n_errors++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random cycle %0d: piso=%0d accion=%0d puertas=%0b llegada=%0b destino=%0d, want %0d %0d %0b %0b %0d",
                             i, piso, accion, puertas, llegada, destino,
                             m_piso, exp_acc, (m_mode == MODE_DOOR), m_lleg, m_dest);
                end
            end
        end
        memoria = 4'd0; boton_abrir = 1'b0;
    endtask

    initial begin
        test_reset();
        test_same_floor();
        test_up_trip();
        test_down_redirect();
        test_invalid();
        test_reset_mid_up();
        test_reopen();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/control_ascensor.md
Name: control_ascensor

Overview:
- Elevator motion/door controller for the 4-floor system.
- Consumes the 4-bit next-request code `memoria` from the request memory.
- Drives back the current floor, motion action and door state that the memory uses to select and clear requests.
- Simulates travel and door dwell with cycle timers, so no shaft sensors are needed.

Parameters:
- TRAVEL_CYCLES, 100, clock cycles to move one floor (≥2).
- DOOR_CYCLES, 50, clock cycles the door stays open (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- memoria  input  4  next request code from request memory; 0 = none.
- boton_abrir  input  1  cabin door-open button; used only with DOOR_REOPEN_EN.
- piso  output  2  current floor, 0..3 = floors 1..4.
- accion  output  2  0 = stopped, 1 = moving up, 2 = moving down; 3 never driven.
- puertas  output  1  1 = door open, 0 = closed.
- llegada  output  1  one-cycle pulse on arrival at any floor.
- destino  output  2  latched target floor.

Behaviour:
- Reset (async, active-high): state=IDLE, piso=0, accion=0, puertas=0, llegada=0, destino=0, both timers=0. Applies immediately mid-travel or mid-dwell; no floor change is completed.
- Code decode tgt(c):
  - 1,5 → 0
  - 2,6,7 → 1
  - 3,8,9 → 2
  - 4,10 → 3
  - 0 and 11..15 are invalid and ignored in every state.
- Target latch: in IDLE, UP and DOWN, a valid `memoria` loads destino=tgt(memoria) on the next edge. In DOOR_OPEN, `memoria` is ignored.
- States: IDLE, UP, DOWN, DOOR_OPEN.
- IDLE (accion=0, puertas=0), on a valid `memoria`:
  - tgt==piso → DOOR_OPEN next cycle.
  - tgt>piso → UP.
  - tgt<piso → DOWN.
  - Otherwise stay.
- UP (accion=1):
  - Travel timer counts 0..TRAVEL_CYCLES-1.
  - At terminal count: piso+1, timer cleared, llegada=1 for that cycle.
  - Arrival decision uses destino including a same-edge update, with the incoming valid code taking priority:
    - new piso==destino, or piso==3 → DOOR_OPEN, accion=0.
    - destino<new piso (request reversed) → IDLE.
    - Otherwise continue UP.
- DOWN (accion=2): mirror of UP, with floor 0 as the forced stop.
- Mid-travel: destino may change. A target already passed is not served until the next IDLE evaluation.
- DOOR_OPEN (accion=0, puertas=1):
  - Door timer counts 0..DOOR_CYCLES-1.
  - At terminal count → IDLE with puertas=0 on the same edge.
  - Request memory clears the floor's codes while puertas=1.
- piso never wraps: no increment at 3, no decrement at 0.
- All outputs are registered. Latency from valid `memoria` in IDLE to accion/puertas change is 1 cycle.
- First floor change occurs TRAVEL_CYCLES cycles after accion goes to 1 or 2.

Optional Feature:
- DOOR_REOPEN_EN defined:
  - In DOOR_OPEN, boton_abrir=1 resets the door timer to 0, holding the door open DOOR_CYCLES more cycles after release.
  - In IDLE, boton_abrir=1 enters DOOR_OPEN at the current floor.
- DOOR_REOPEN_EN undefined: boton_abrir is ignored; no reopen logic is synthesized.

Test Plan:
- Reset, then memoria=5 held 1 cycle at piso=0 → next cycle puertas=1, accion=0. After 50 cycles puertas=0, state IDLE.
- From IDLE at piso=0, memoria=4 for 1 cycle → accion=1, destino=3.
  - piso steps 1, 2, 3 at 100-cycle intervals, with llegada pulsing three times.
  - At piso=3: accion=0, puertas=1.
- From piso=3, memoria=1 → accion=2. During the second floor of travel present memoria=6 (destino=1) → stop at piso=1 with puertas=1; piso never reaches 0.
- memoria=12 and memoria=0 in IDLE → no output change for 200 cycles.
- Assert reset mid-UP (timer=40, piso=1) → asynchronously piso=0, accion=0, puertas=0, llegada=0. After release, the next valid code starts from floor 0.
- DOOR_REOPEN_EN: pulse boton_abrir at door timer=45 → puertas stays 1 for 50 more cycles. Without the macro, the door closes at 50 regardless.
